// File: rtl/pc_unit_pkg.sv
// Shared types for the program-counter unit.
package pc_unit_pkg;
    typedef enum logic [1:0] {
        PC_SRC__INCR       = 2'd0,
        PC_SRC__JUMP       = 2'd1,
        PC_SRC__ALU_RESULT = 2'd2,
        PC_SRC__TRAP       = 2'd3
    } pc_src_t;
endpackage

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection, misaligned-target trap
// redirect and a small circular return-address stack.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int                XLEN         = 32,
    parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
    parameter logic [XLEN-1:0]   TRAP_VECTOR  = 'h100,
    parameter int                IALIGN       = 32,
    parameter int                RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_en,
    input  logic            pc_update,
    input  pc_src_t         pc_src,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [XLEN-1:0] alu_result,
    input  logic            ras_push,
    input  logic            ras_pop,
    output logic [XLEN-1:0] pc_cur,
    output logic [XLEN-1:0] pc_old,
    output logic [XLEN-1:0] pc_next,
    output logic            misaligned,
    output logic [XLEN-1:0] bad_addr,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_valid,
    output logic            ras_underflow
);

    localparam int              PW   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PW:0]     FULL = (PW + 1)'(RAS_DEPTH);
    localparam logic [XLEN-1:0] INC  = XLEN'(4);

    logic [XLEN-1:0] pc_cur_q, pc_cur_d;
    logic [XLEN-1:0] pc_old_q, pc_old_d;
    logic [XLEN-1:0] bad_addr_q, bad_addr_d;
    logic            mis_q, mis_d;
    logic            unf_q, unf_d;
    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [XLEN-1:0] mem_d [RAS_DEPTH];
    logic [PW-1:0]   top_q, top_d;
    logic [PW:0]     cnt_q, cnt_d;

    logic            tgt_mis;
    logic [XLEN-1:0] link;
    logic [PW-1:0]   top_inc;

    always_comb begin
        pc_next = pc_cur_q + INC;
        unique case (pc_src)
            PC_SRC__INCR:       pc_next = pc_cur_q + INC;
            PC_SRC__JUMP:       pc_next = pc_old_q + imm_ext;
            PC_SRC__ALU_RESULT: pc_next = alu_result & ~XLEN'(1);
            PC_SRC__TRAP:       pc_next = TRAP_VECTOR;
        endcase
    end

    // With 16-bit alignment bit 0 is already clear, so nothing can fault.
    assign tgt_mis = (IALIGN == 32) && (pc_src != PC_SRC__TRAP)
                     && pc_next[1];
    assign link    = pc_old_q + INC;
    assign top_inc = top_q + 1'b1;

    always_comb begin
        pc_cur_d   = pc_cur_q;
        pc_old_d   = pc_old_q;
        bad_addr_d = bad_addr_q;
        mis_d      = 1'b0;
        unf_d      = 1'b0;
        mem_d      = mem_q;
        top_d      = top_q;
        cnt_d      = cnt_q;

        if (fetch_en) pc_old_d = pc_cur_q;

        if (pc_update) begin
            if (tgt_mis) begin
                pc_cur_d   = TRAP_VECTOR;
                bad_addr_d = pc_next;
                mis_d      = 1'b1;
            end else begin
                pc_cur_d = pc_next;
            end
        end

        // Push+pop on a non-empty stack replaces the top in place.
        if (ras_push && (!ras_pop || cnt_q == '0)) begin
            top_d          = top_inc;
            mem_d[top_inc] = link;
            if (cnt_q != FULL) cnt_d = cnt_q + 1'b1;
        end else if (ras_push) begin
            mem_d[top_q] = link;
        end else if (ras_pop) begin
            if (cnt_q != '0) begin
                top_d = top_q - 1'b1;
                cnt_d = cnt_q - 1'b1;
            end else begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_cur_q   <= RESET_VECTOR;
            pc_old_q   <= RESET_VECTOR;
            bad_addr_q <= '0;
            mis_q      <= 1'b0;
            unf_q      <= 1'b0;
            top_q      <= '0;
            cnt_q      <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            pc_cur_q   <= pc_cur_d;
            pc_old_q   <= pc_old_d;
            bad_addr_q <= bad_addr_d;
            mis_q      <= mis_d;
            unf_q      <= unf_d;
            top_q      <= top_d;
            cnt_q      <= cnt_d;
            mem_q      <= mem_d;
        end
    end

    assign pc_cur        = pc_cur_q;
    assign pc_old        = pc_old_q;
    assign bad_addr      = bad_addr_q;
    assign misaligned    = mis_q;
    assign ras_underflow = unf_q;
    assign ras_valid     = (cnt_q != '0);
    assign ras_top       = (cnt_q != '0) ? mem_q[top_q] : '0;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: IALIGN=32 and IALIGN=16 instances share stimulus
// and are compared against a stack/arithmetic reference model.
module tb_pc_unit;
    import pc_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en, pc_update, ras_push, ras_pop;
    pc_src_t     src;
    logic [31:0] imm_ext, alu_result;

    logic [31:0] o_pc [2];
    logic [31:0] o_old [2];
    logic [31:0] o_next [2];
    logic [31:0] o_bad [2];
    logic [31:0] o_top [2];
    logic        o_mis [2];
    logic        o_valid [2];
    logic        o_unf [2];

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state, index 0 = IALIGN 32, 1 = IALIGN 16
    logic [31:0] m_pc [2];
    logic [31:0] m_old [2];
    logic [31:0] m_bad [2];
    logic        m_mis [2];
    logic        m_unf [2];
    logic [31:0] m_stk [2][4];
    int          m_cnt [2];

    always #5 clk = ~clk;

    pc_unit #(.IALIGN(32)) u32 (
        .clk(clk), .reset(reset), .fetch_en(fetch_en),
        .pc_update(pc_update), .pc_src(src), .imm_ext(imm_ext),
        .alu_result(alu_result), .ras_push(ras_push), .ras_pop(ras_pop),
        .pc_cur(o_pc[0]), .pc_old(o_old[0]), .pc_next(o_next[0]),
        .misaligned(o_mis[0]), .bad_addr(o_bad[0]), .ras_top(o_top[0]),
        .ras_valid(o_valid[0]), .ras_underflow(o_unf[0])
    );

    pc_unit #(.IALIGN(16)) u16 (
        .clk(clk), .reset(reset), .fetch_en(fetch_en),
        .pc_update(pc_update), .pc_src(src), .imm_ext(imm_ext),
        .alu_result(alu_result), .ras_push(ras_push), .ras_pop(ras_pop),
        .pc_cur(o_pc[1]), .pc_old(o_old[1]), .pc_next(o_next[1]),
        .misaligned(o_mis[1]), .bad_addr(o_bad[1]), .ras_top(o_top[1]),
        .ras_valid(o_valid[1]), .ras_underflow(o_unf[1])
    );

    function automatic logic [31:0] m_target(int k);
        case (src)
            PC_SRC__INCR:       return m_pc[k] + 32'd4;
            PC_SRC__JUMP:       return m_old[k] + imm_ext;
            PC_SRC__ALU_RESULT: return {alu_result[31:1], 1'b0};
            default:            return 32'h100;
        endcase
    endfunction

    function automatic logic [31:0] m_top(int k);
        return (m_cnt[k] == 0) ? 32'd0 : m_stk[k][m_cnt[k]-1];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 0; m_old[k] = 0; m_bad[k] = 0;
            m_mis[k] = 0; m_unf[k] = 0; m_cnt[k] = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic [31:0] tgt, link, pc_pre;
            logic        mis;
            tgt    = m_target(k);
            mis    = (k == 0) && (src != PC_SRC__TRAP) && tgt[1];
            link   = m_old[k] + 32'd4;
            pc_pre = m_pc[k];
            if (fetch_en) m_old[k] = pc_pre;
            m_mis[k] = pc_update && mis;
            if (pc_update) begin
                if (mis) begin
                    m_pc[k]  = 32'h100;
                    m_bad[k] = tgt;
                end else begin
                    m_pc[k] = tgt;
                end
            end
            m_unf[k] = 0;
            if (ras_push && (!ras_pop || m_cnt[k] == 0)) begin
                if (m_cnt[k] == 4) begin
                    for (int j = 0; j < 3; j++) m_stk[k][j] = m_stk[k][j+1];
                    m_stk[k][3] = link;
                end else begin
                    m_stk[k][m_cnt[k]] = link;
                    m_cnt[k]++;
                end
            end else if (ras_push) begin
                m_stk[k][m_cnt[k]-1] = link;
            end else if (ras_pop) begin
                if (m_cnt[k] > 0) m_cnt[k]--;
                else m_unf[k] = 1;
            end
        end
    endtask

    task automatic cmp_model(input string tag);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_pc[k] !== m_pc[k]) begin
                n_fail++;
                $display("FAIL %s i%0d pc_cur got %h want %h",
                         tag, k, o_pc[k], m_pc[k]);
            end
            n_checks++;
            if (o_old[k] !== m_old[k]) begin
                n_fail++;
                $display("FAIL %s i%0d pc_old got %h want %h",
                         tag, k, o_old[k], m_old[k]);
            end
            n_checks++;
            if (o_mis[k] !== m_mis[k] || o_bad[k] !== m_bad[k]) begin
                n_fail++;
                $display("FAIL %s i%0d mis/bad got %b/%h want %b/%h",
                         tag, k, o_mis[k], o_bad[k], m_mis[k], m_bad[k]);
            end
            n_checks++;
            if (o_top[k] !== m_top(k) || o_valid[k] !== (m_cnt[k] != 0)
                || o_unf[k] !== m_unf[k]) begin
                n_fail++;
                $display("FAIL %s i%0d ras top/v/unf got %h/%b/%b want %h/%b/%b",
                         tag, k, o_top[k], o_valid[k], o_unf[k],
                         m_top(k), m_cnt[k] != 0, m_unf[k]);
            end
        end
    endtask

    task automatic step(input logic fe, input logic upd, input pc_src_t s,
                        input logic [31:0] imm, input logic [31:0] alu,
                        input logic pu, input logic po);
        fetch_en = fe; pc_update = upd; src = s;
        imm_ext = imm; alu_result = alu; ras_push = pu; ras_pop = po;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_next[k] !== m_target(k)) begin
                n_fail++;
                $display("FAIL pc_next i%0d got %h want %h",
                         k, o_next[k], m_target(k));
            end
        end
        model_edge();
        @(posedge clk);
        #1;
        fetch_en = 0; pc_update = 0; ras_push = 0; ras_pop = 0;
        cmp_model("step");
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        #1;
        model_reset();
        cmp_model("async_reset");
        @(negedge clk);
        reset = 0;
    endtask

    task automatic set_old(input logic [31:0] a);
        step(0, 1, PC_SRC__ALU_RESULT, 0, a, 0, 0);
        step(1, 0, PC_SRC__INCR, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (o_pc[0] !== 0 || o_old[0] !== 0 || o_bad[0] !== 0
            || o_mis[0] !== 0 || o_unf[0] !== 0 || o_valid[0] !== 0
            || o_top[0] !== 0) begin
            n_fail++;
            $display("FAIL reset_vals pc %h old %h bad %h v %b top %h want zeros",
                     o_pc[0], o_old[0], o_bad[0], o_valid[0], o_top[0]);
        end
    endtask

    task automatic test_jal();
        do_reset();
        step(1, 0, PC_SRC__INCR, 0, 0, 0, 0);
        step(0, 1, PC_SRC__JUMP, 32'd16, 0, 0, 0);
        n_checks++;
        if (o_pc[0] !== 32'd16 || o_old[0] !== 0 || o_mis[0] !== 0) begin
            n_fail++;
            $display("FAIL jal pc %h old %h mis %b want 10/0/0",
                     o_pc[0], o_old[0], o_mis[0]);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            step(1, 0, PC_SRC__INCR, 0, 0, 0, 0);
            step(0, 1, PC_SRC__INCR, 0, 0, 0, 0);
            n_checks++;
            if (o_pc[0] !== 32'(4 * i) || o_old[0] !== 32'(4 * (i - 1))) begin
                n_fail++;
                $display("FAIL seq%0d pc %h old %h want %h %h", i,
                         o_pc[0], o_old[0], 4 * i, 4 * (i - 1));
            end
        end
        step(0, 1, PC_SRC__JUMP, -32'sd8, 0, 0, 0);
        n_checks++;
        if (o_pc[0] !== 0) begin
            n_fail++;
            $display("FAIL seq_back pc got %h want 0", o_pc[0]);
        end
    endtask

    task automatic test_misalign();
        do_reset();
        step(0, 1, PC_SRC__ALU_RESULT, 0, 32'h23, 0, 0);
        n_checks++;
        if (o_pc[0] !== 32'h100 || o_bad[0] !== 32'h22 || o_mis[0] !== 1) begin
            n_fail++;
            $display("FAIL mis32 pc %h bad %h mis %b want 100/22/1",
                     o_pc[0], o_bad[0], o_mis[0]);
        end
        n_checks++;
        if (o_pc[1] !== 32'h22 || o_mis[1] !== 0) begin
            n_fail++;
            $display("FAIL mis16 pc %h mis %b want 22/0", o_pc[1], o_mis[1]);
        end
        step(0, 0, PC_SRC__INCR, 0, 0, 0, 0);
        n_checks++;
        if (o_mis[0] !== 0 || o_bad[0] !== 32'h22) begin
            n_fail++;
            $display("FAIL mis_pulse mis %b bad %h want 0/22", o_mis[0], o_bad[0]);
        end
    endtask

    task automatic test_ras_wrap();
        logic [31:0] exp_top [4];
        exp_top[0] = 32'h44; exp_top[1] = 32'h34;
        exp_top[2] = 32'h24; exp_top[3] = 32'h14;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_old(32'(16 * i));
            step(0, 0, PC_SRC__INCR, 0, 0, 1, 0);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (o_top[0] !== exp_top[i] || o_valid[0] !== 1) begin
                n_fail++;
                $display("FAIL ras_wrap%0d top %h v %b want %h/1",
                         i, o_top[0], o_valid[0], exp_top[i]);
            end
            step(0, 0, PC_SRC__INCR, 0, 0, 0, 1);
        end
        step(0, 0, PC_SRC__INCR, 0, 0, 0, 1);
        n_checks++;
        if (o_valid[0] !== 0 || o_unf[0] !== 1 || o_top[0] !== 0) begin
            n_fail++;
            $display("FAIL ras_underflow v %b unf %b top %h want 0/1/0",
                     o_valid[0], o_unf[0], o_top[0]);
        end
        step(0, 0, PC_SRC__INCR, 0, 0, 0, 0);
        n_checks++;
        if (o_unf[0] !== 0) begin
            n_fail++;
            $display("FAIL unf_pulse got %b want 0", o_unf[0]);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_old(32'h10);
        step(0, 0, PC_SRC__INCR, 0, 0, 1, 0);
        set_old(32'h50);
        step(0, 0, PC_SRC__INCR, 0, 0, 1, 1);
        n_checks++;
        if (o_top[0] !== 32'h54 || o_valid[0] !== 1) begin
            n_fail++;
            $display("FAIL pushpop top %h v %b want 54/1", o_top[0], o_valid[0]);
        end
        step(0, 0, PC_SRC__INCR, 0, 0, 0, 1);
        n_checks++;
        if (o_valid[0] !== 0 || o_unf[0] !== 0) begin
            n_fail++;
            $display("FAIL pushpop_drain v %b unf %b want 0/0",
                     o_valid[0], o_unf[0]);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(0, 0, PC_SRC__INCR, 0, 0, 1, 0);
        step(0, 0, PC_SRC__INCR, 0, 0, 1, 0);
        step(0, 1, PC_SRC__JUMP, 32'd16, 0, 0, 0);
        n_checks++;
        if (o_pc[0] !== 32'd16 || o_valid[0] !== 1) begin
            n_fail++;
            $display("FAIL pre_reset pc %h v %b want 10/1", o_pc[0], o_valid[0]);
        end
        // fault pending in the pulse flop when reset lands
        step(0, 1, PC_SRC__ALU_RESULT, 0, 32'h6, 0, 1);
        do_reset();
        n_checks++;
        if (o_pc[0] !== 0 || o_old[0] !== 0 || o_valid[0] !== 0
            || o_mis[0] !== 0 || o_unf[0] !== 0) begin
            n_fail++;
            $display("FAIL async_reset pc %h old %h v %b mis %b unf %b want 0s",
                     o_pc[0], o_old[0], o_valid[0], o_mis[0], o_unf[0]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(59) == 0) do_reset();
            step(1'($urandom), 1'($urandom), pc_src_t'($urandom_range(3)),
                 $urandom & 32'h0000_0FFE, $urandom,
                 1'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        reset = 1; fetch_en = 0; pc_update = 0; ras_push = 0; ras_pop = 0;
        src = PC_SRC__INCR; imm_ext = 0; alu_result = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        test_reset();
        test_jal();
        test_sequential();
        test_misalign();
        test_ras_wrap();
        test_simultaneous();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the multi-cycle core. It replaces the fixed-width PC logic inside `fetch`. It holds `pc_cur` and `pc_old` and computes the next PC for sequential, JAL/branch, JALR and trap sources. It also detects misaligned control-flow targets and redirects them to a trap vector. A small circular return-address stack (RAS) records call links and exposes a predicted return target for decode and debug.

## Interface
Parameters:
- `XLEN`, 32, datapath/address width.
- `RESET_VECTOR`, 0, PC value after reset.
- `TRAP_VECTOR`, 32'h100, redirect target on misaligned target; must be 4-byte aligned.
- `IALIGN`, 32, instruction alignment in bits; legal values are 32 and 16.
- `RAS_DEPTH`, 4, number of RAS entries; must be a power of two and at least 2.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `fetch_en`  in  1  FETCH-state strobe; latches `pc_cur` into `pc_old`.
- `pc_update`  in  1  commits the next PC selected by `pc_src`.
- `pc_src`  in  `pc_src_t`  one of `PC_SRC__INCR`, `PC_SRC__JUMP`, `PC_SRC__ALU_RESULT`, `PC_SRC__TRAP`.
- `imm_ext`  in  XLEN  sign-extended J/B immediate.
- `alu_result`  in  XLEN  JALR target (rs1 + imm).
- `ras_push`  in  1  call hint: push link `pc_old + 4`.
- `ras_pop`  in  1  return hint: pop top entry.
- `pc_cur`  out  XLEN  current PC (registered).
- `pc_old`  out  XLEN  PC of the instruction in flight (registered).
- `pc_next`  out  XLEN  combinational candidate next PC.
- `misaligned`  out  1  one-cycle pulse after a misaligned redirect.
- `bad_addr`  out  XLEN  last faulting target; held until the next fault or reset.
- `ras_top`  out  XLEN  top RAS entry; 0 when empty.
- `ras_valid`  out  1  RAS non-empty.
- `ras_underflow`  out  1  one-cycle pulse after a pop on an empty RAS.

## Operation
- `pc_next` is computed per `pc_src`:
  - INCR: `pc_cur + 4`.
  - JUMP: `pc_old + imm_ext`, modulo 2^XLEN.
  - ALU_RESULT: `alu_result & ~1`.
  - TRAP: `TRAP_VECTOR`.
- A target is misaligned when `IALIGN == 32` and bit 1 of the target is set. With `IALIGN == 16` no target is misaligned, because bit 0 is always cleared or zero. TRAP is never checked.
- On `pc_update`:
  - If the target is aligned: `pc_cur <= pc_next`.
  - If misaligned: `pc_cur <= TRAP_VECTOR`, `bad_addr <= pc_next`, and `misaligned` pulses.
- On `fetch_en`: `pc_old <= pc_cur`. If `fetch_en` and `pc_update` occur in the same cycle, `pc_old` takes the pre-edge `pc_cur`, and `pc_cur` takes the new target.
- RAS is a circular buffer with a top pointer and a count (0..RAS_DEPTH):
  - Push only: write the link at top+1 and advance top. The count increments, saturating at RAS_DEPTH. When full, the oldest entry is silently overwritten by wrap-around.
  - Pop only: if count > 0, retreat top and decrement count. If empty, nothing changes and `ras_underflow` pulses.
  - Push and pop together: overwrite the top entry with the link; count is unchanged. If empty, this behaves as a push only.
- `ras_top` and `ras_valid` reflect state after the edge (registered view).

## Timing
- Reset values: `pc_cur` = `pc_old` = RESET_VECTOR; `misaligned` = 0; `bad_addr` = 0; `ras_underflow` = 0; RAS count = 0, so `ras_valid` = 0 and `ras_top` = 0.
- Reset takes effect without a clock edge; asserting it mid-operation discards any pending update.
- Latency: `pc_next` has 0 cycles (combinational). `pc_cur`, `pc_old` and RAS state update on the edge that samples the strobe.
- `misaligned` and `ras_underflow` are high for exactly the one cycle following the faulting edge.
- No handshakes: strobes are single-cycle, issued by the control FSM; back-to-back strobes are legal every cycle.

## Test plan
- JAL: reset; `fetch_en` at PC 0; next cycle `pc_update` with JUMP, `imm_ext` = 16 -> `pc_cur` = 16, `pc_old` = 0, `misaligned` = 0.
- Sequential: three fetch/INCR pairs from reset -> `pc_cur` steps 4, 8, 12; `pc_old` steps 0, 4, 8. Then JUMP with `imm_ext` = -8 at `pc_old` = 8 -> `pc_cur` = 0.
- JALR/misalign: ALU_RESULT with `alu_result` = 0x23.
  - IALIGN=32 -> `pc_cur` = 0x100, `bad_addr` = 0x22, one-cycle `misaligned` pulse.
  - IALIGN=16 -> `pc_cur` = 0x22, no pulse.
- RAS wrap: DEPTH=4; five pushes with `pc_old` = 0x0, 0x10, 0x20, 0x30, 0x40.
  - Four pops -> `ras_top` before each pop reads 0x44, 0x34, 0x24, 0x14.
  - Fifth pop -> `ras_valid` = 0, `ras_underflow` pulses, `ras_top` = 0.
- Simultaneous: push 0x10 link, then push+pop with `pc_old` = 0x50 -> `ras_top` = 0x54, count still 1. A single pop then empties the RAS.
- Async reset: assert `reset` between edges after `pc_cur` = 16 with 2 RAS entries -> immediately `pc_cur` = 0, `pc_old` = 0, `ras_valid` = 0, all pulses 0.
